// File: rtl/mole_spawner.sv
// Mole responder: picks a pseudo-random non-repeating LED on each request and runs
// the per-mole millisecond countdown that the game FSM samples as timeout.
module mole_spawner #(
    parameter int unsigned NUM_LEDS    = 18,
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter int unsigned LEVEL1_MS   = 1500,
    parameter int unsigned LEVEL2_MS   = 1000,
    parameter int unsigned LEVEL3_MS   = 600,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          level_number,
    input  logic                ready_for_mole,
    input  logic                timeout_start,
    output logic [NUM_LEDS-1:0] led_number,
    output logic [4:0]          mole_index,
    output logic                timeout,
    output logic [15:0]         time_left_ms,
    output logic                mole_valid
);

    localparam int unsigned PreW    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int unsigned MaxSub  = 31 / NUM_LEDS;
    localparam logic [PreW-1:0] PreMax = PreW'(CLKS_PER_MS - 1);
    localparam logic [5:0]  NumLeds = 6'(NUM_LEDS);
    localparam logic [15:0] Dur1    = 16'(LEVEL1_MS);
    localparam logic [15:0] Dur2    = 16'(LEVEL2_MS);
    localparam logic [15:0] Dur3    = 16'(LEVEL3_MS);

    typedef enum logic [1:0] {StIdle, StArmed, StCounting, StExpired} state_e;

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [PreW-1:0]     presc_q, presc_d;
    logic [15:0]         tl_q, tl_d;
    logic                to_q, to_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    // Current mole index doubles as the previous-index register for repeat avoidance.
    logic [4:0]          idx_q, idx_d;

    logic [5:0]  raw;
    logic [4:0]  pick;
    logic [15:0] dur;

    always_comb begin
        raw = {1'b0, lfsr_q[4:0]};
        for (int unsigned i = 0; i < MaxSub; i++) begin
            if (raw >= NumLeds) raw = raw - NumLeds;
        end
        if (raw[4:0] == idx_q) pick = (raw == NumLeds - 6'd1) ? 5'd0 : raw[4:0] + 5'd1;
        else                   pick = raw[4:0];
    end

    always_comb begin
        case (level_number)
            2'b10:   dur = Dur2;
            2'b11:   dur = Dur3;
            default: dur = Dur1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tl_d    = tl_q;
        to_d    = to_q;
        led_d   = led_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

        if (ready_for_mole) begin
            idx_d   = pick;
            led_d   = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pick;
            tl_d    = dur;
            presc_d = '0;
            to_d    = 1'b1;
            state_d = StArmed;
        end else begin
            case (state_q)
                StArmed, StCounting: begin
                    if (timeout_start) begin
                        state_d = StCounting;
                        if (presc_q == PreMax) begin
                            presc_d = '0;
                            tl_d    = tl_q - 16'd1;
                            if (tl_q == 16'd1) begin
                                to_d    = 1'b0;
                                state_d = StExpired;
                            end
                        end else begin
                            presc_d = presc_q + PreW'(1);
                        end
                    end
                end
                StExpired: begin
                    to_d = 1'b0;
                    tl_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            lfsr_q  <= LFSR_SEED;
            presc_q <= '0;
            tl_q    <= '0;
            to_q    <= 1'b0;
            led_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            presc_q <= presc_d;
            tl_q    <= tl_d;
            to_q    <= to_d;
            led_q   <= led_d;
            idx_q   <= idx_d;
        end
    end

    assign led_number   = led_q;
    assign mole_index   = idx_q;
    assign timeout      = to_q;
    assign time_left_ms = tl_q;
    assign mole_valid   = timeout_start & to_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: countdown vector tables, a request scoreboard
// backed by an LFSR/pick model, and hand-written reload and async-reset sequences.
module tb_mole_spawner;

    localparam int unsigned NUM_LEDS = 18;
    localparam int unsigned CLKS     = 4;
    localparam int unsigned L1       = 3;
    localparam int unsigned L2       = 2;
    localparam int unsigned L3       = 1;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic                clk;
    logic                reset;
    logic [1:0]          level_number;
    logic                ready_for_mole;
    logic                timeout_start;
    logic [NUM_LEDS-1:0] led_number;
    logic [4:0]          mole_index;
    logic                timeout;
    logic [15:0]         time_left_ms;
    logic                mole_valid;

    mole_spawner #(
        .NUM_LEDS    (NUM_LEDS),
        .CLKS_PER_MS (CLKS),
        .LEVEL1_MS   (L1),
        .LEVEL2_MS   (L2),
        .LEVEL3_MS   (L3),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .level_number   (level_number),
        .ready_for_mole (ready_for_mole),
        .timeout_start  (timeout_start),
        .led_number     (led_number),
        .mole_index     (mole_index),
        .timeout        (timeout),
        .time_left_ms   (time_left_ms),
        .mole_valid     (mole_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR tracking the DUT's free-running generator.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic int exp_pick(input logic [15:0] s, input int prev);
        int r;
        r = int'(s[4:0]) % NUM_LEDS;
        if (r == prev) r = (r + 1) % NUM_LEDS;
        return r;
    endfunction

    typedef struct {
        int          idx;
        logic [15:0] tl;
    } exp_t;
    exp_t sb[$];

    int                  m_prev;
    logic [NUM_LEDS-1:0] cur_led;
    logic [NUM_LEDS-1:0] seen;
    logic [NUM_LEDS-1:0] all_ones;

    task automatic request(input logic [1:0] lvl, input logic start_too);
        exp_t                e;
        logic [NUM_LEDS-1:0] el;
        level_number   = lvl;
        ready_for_mole = 1'b1;
        timeout_start  = start_too;
        e.idx = exp_pick(m_lfsr, m_prev);
        e.tl  = (lvl == 2'b10) ? 16'(L2) : (lvl == 2'b11) ? 16'(L3) : 16'(L1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        ready_for_mole = 1'b0;
        timeout_start  = 1'b0;
        e = sb.pop_front();
        el = '0;
        el[e.idx] = 1'b1;
        check("req_index", 32'(mole_index), 32'(e.idx));
        check("req_led", 32'(led_number), 32'(el));
        check("req_time_left", 32'(time_left_ms), 32'(e.tl));
        check("req_timeout", 32'(timeout), 32'd1);
        check("req_onehot", 32'($countones(led_number)), 32'd1);
        check("req_range", 32'(mole_index < NUM_LEDS), 32'd1);
        check("req_no_repeat", 32'(int'(mole_index) != m_prev), 32'd1);
        m_prev = e.idx;
        cur_led = el;
        seen[e.idx] = 1'b1;
    endtask

    typedef struct {
        logic        start;
        logic        exp_valid;  // mole_valid before the edge
        logic        exp_to;     // timeout after the edge
        logic [15:0] exp_tl;     // time_left_ms after the edge
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic s, input logic v, input logic t, input int tl);
        vec_t x;
        x.start = s;
        x.exp_valid = v;
        x.exp_to = t;
        x.exp_tl = 16'(tl);
        vecs.push_back(x);
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            timeout_start = vecs[i].start;
            #1;
            check($sformatf("vec%0d_valid", i), 32'(mole_valid), 32'(vecs[i].exp_valid));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
            check($sformatf("vec%0d_time_left", i), 32'(time_left_ms), 32'(vecs[i].exp_tl));
            check($sformatf("vec%0d_led_held", i), 32'(led_number), 32'(cur_led));
        end
        timeout_start = 1'b0;
    endtask

    task automatic cycles(input int n, input logic start);
        timeout_start = start;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        assert (CLKS > 0 && L1 > 0 && L2 > 0 && L3 > 0);

        // Rows 0..4: level 3 (1 ms) countdown with timeout_start held high.
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1);
        add(1, 1, 0, 0);
        add(1, 0, 0, 0);
        // Rows 5..27: level 1 (3 ms), 5 high, 10 low (frozen), then resume to expiry.
        for (int i = 0; i < 3; i++) add(1, 1, 1, 3);
        for (int i = 0; i < 2; i++) add(1, 1, 1, 2);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 2);
        for (int i = 0; i < 2; i++) add(1, 1, 1, 2);
        for (int i = 0; i < 4; i++) add(1, 1, 1, 1);
        add(1, 1, 0, 0);
        add(1, 0, 0, 0);

        reset = 1'b1;
        level_number = 2'b00;
        ready_for_mole = 1'b0;
        timeout_start = 1'b0;
        m_prev = 0;
        cur_led = '0;
        seen = '0;
        all_ones = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Scenario 1: idle with stray timeout_start, then a level-2 request.
        cycles(8, 1'b0);
        cycles(6, 1'b1);
        cycles(6, 1'b0);
        check("idle_led", 32'(led_number), 32'd0);
        check("idle_timeout", 32'(timeout), 32'd0);
        check("idle_time_left", 32'(time_left_ms), 32'd0);
        check("idle_index", 32'(mole_index), 32'd0);
        timeout_start = 1'b1;
        #1;
        check("idle_valid", 32'(mole_valid), 32'd0);
        timeout_start = 1'b0;
        request(2'b10, 1'b0);

        // Scenario 2: 1 ms level expires exactly CLKS cycles after start.
        request(2'b11, 1'b0);
        run_vecs(0, 4);

        // Scenario 3: freeze while timeout_start is low, resume to expiry.
        request(2'b01, 1'b0);
        run_vecs(5, 27);

        // Scenario 4: 200 requests at varying gaps.
        seen = '0;
        for (int n = 0; n < 200; n++) begin
            cycles($urandom_range(0, 3), 1'b0);
            request(2'($urandom_range(0, 3)), 1'b0);
        end
        check("all_indices_seen", 32'(seen), 32'(all_ones));

        // Scenario 5: mid-count reload, then simultaneous request + start.
        request(2'b01, 1'b0);
        cycles(4, 1'b1);
        check("midcount_time_left", 32'(time_left_ms), 32'd2);
        request(2'b01, 1'b0);
        request(2'b11, 1'b1);
        cycles(3, 1'b1);
        check("simul_timeout_3", 32'(timeout), 32'd1);
        check("simul_time_left_3", 32'(time_left_ms), 32'd1);
        cycles(1, 1'b1);
        check("simul_timeout_4", 32'(timeout), 32'd0);
        check("simul_time_left_4", 32'(time_left_ms), 32'd0);
        timeout_start = 1'b0;

        // Scenario 6: async reset between edges while counting.
        request(2'b01, 1'b0);
        cycles(2, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("areset_timeout", 32'(timeout), 32'd0);
        check("areset_led", 32'(led_number), 32'd0);
        check("areset_time_left", 32'(time_left_ms), 32'd0);
        check("areset_index", 32'(mole_index), 32'd0);
        timeout_start = 1'b0;
        m_prev = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        request(2'b10, 1'b0);
        // Seed 16'hACE1 has low bits 5'd1, so the first pick is LED 1.
        check("seed_golden_index", 32'(mole_index), 32'd1);
        check("seed_golden_led", 32'(led_number), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
